// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice with a registered carry processes
// a WIDTH-bit operation LSB digit first, with valid/ready handshakes on both sides.
module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_last;
    logic [DIGIT:0]     w_slice;
    logic               w_c_msb;

    // Operands shift right each digit, so the slice always reads the low DIGIT bits.
    assign w_last  = (r_cnt == CNT_W'(NDIG - 1));
    assign w_slice = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
    // Carry into the top bit recovered from that bit's sum: c = a ^ b ^ s.
    assign w_c_msb = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_slice[DIGIT-1];

    // NOTE: state and datapath registers use non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: next-state logic assigns a default first so no path infers a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (in_valid)  w_next = S_RUN;
            S_RUN:  if (w_last)    w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default:               w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? ~cin : cin;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_slice[DIGIT];
                    r_sum[int'(r_cnt)*DIGIT +: DIGIT] <= w_slice[DIGIT-1:0];
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cout <= w_slice[DIGIT];
                        r_ovf  <= w_c_msb ^ w_slice[DIGIT];
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Directed bench for digit_serial_addsub: three WIDTH=16 instances (DIGIT 4, 1, 16)
// and one WIDTH=4/DIGIT=4 instance for the exhaustive add sweep.
module tb_digit_serial_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a16, b16;
    logic [3:0]  a4, b4;
    logic        cin, sub, out_ready;

    logic        in_valid16  [3];
    logic        in_ready16  [3];
    logic        out_valid16 [3];
    logic [15:0] sum16       [3];
    logic        cout16      [3];
    logic        ovf16       [3];

    logic        in_valid4, in_ready4, out_valid4, cout4, ovf4;
    logic [3:0]  sum4;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_lat [3] = '{4, 16, 1};

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        c;
        logic        o;
    } vec_t;

    vec_t vecs [6] = '{
        '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
        '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
        '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
        '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0},
        '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0},
        '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0}
    };

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DG = (g == 0) ? 4 : (g == 1) ? 1 : 16;
        digit_serial_addsub #(.WIDTH(16), .DIGIT(DG)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid16[g]),
            .in_ready  (in_ready16[g]),
            .a         (a16),
            .b         (b16),
            .cin       (cin),
            .sub       (sub),
            .out_valid (out_valid16[g]),
            .out_ready (out_ready),
            .sum       (sum16[g]),
            .cout      (cout16[g]),
            .ovf       (ovf16[g])
        );
    end

    digit_serial_addsub #(.WIDTH(4), .DIGIT(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .sum       (sum4),
        .cout      (cout4),
        .ovf       (ovf4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One operation on 16-bit instance k with out_ready high; inputs are scrambled
    // during RUN to show they are ignored outside IDLE.
    task automatic run16(input int k, input vec_t v, input string tag);
        int n;
        check($sformatf("%s.in_ready", tag), 32'(in_ready16[k]), 32'd1);
        a16 = v.a; b16 = v.b; cin = v.cin; sub = v.sub;
        in_valid16[k] = 1'b1;
        @(negedge clk);
        in_valid16[k] = 1'b0;
        a16 = ~v.a; b16 = v.b ^ 16'h5A5A; cin = ~v.cin; sub = ~v.sub;
        n = 0;
        while (!out_valid16[k] && n < 64) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s.latency", tag), 32'(n), 32'(exp_lat[k]));
        check($sformatf("%s.sum", tag), 32'(sum16[k]), 32'(v.s));
        check($sformatf("%s.cout", tag), 32'(cout16[k]), 32'(v.c));
        check($sformatf("%s.ovf", tag), 32'(ovf16[k]), 32'(v.o));
        @(negedge clk);
        check($sformatf("%s.out_valid_drop", tag), 32'(out_valid16[k]), 32'd0);
        check($sformatf("%s.in_ready_back", tag), 32'(in_ready16[k]), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t bp;
        rst = 1'b1; out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
        a16 = '0; b16 = '0; a4 = '0; b4 = '0; in_valid4 = 1'b0;
        for (int k = 0; k < 3; k++) in_valid16[k] = 1'b0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst%0d.in_ready", k), 32'(in_ready16[k]), 32'd1);
            check($sformatf("rst%0d.out_valid", k), 32'(out_valid16[k]), 32'd0);
            check($sformatf("rst%0d.sum", k), 32'(sum16[k]), 32'd0);
            check($sformatf("rst%0d.cout_ovf", k), 32'({cout16[k], ovf16[k]}), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors on every digit size.
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 6; i++)
                run16(k, vecs[i], $sformatf("k%0d.v%0d", k, i));

        // Backpressure: 0x1234 + 0x0FFF = 0x2233, held for 5 cycles with out_ready low.
        bp = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
        out_ready = 1'b0;
        a16 = bp.a; b16 = bp.b; cin = 1'b0; sub = 1'b0;
        in_valid16[0] = 1'b1;
        @(negedge clk);
        a16 = 16'hDEAD; b16 = 16'hBEEF; sub = 1'b1;
        begin
            int n = 0;
            while (!out_valid16[0] && n < 64) begin
                @(negedge clk);
                n++;
                a16 = a16 + 16'h1111;
            end
            check("bp.latency", 32'(n), 32'd4);
        end
        in_valid16[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp%0d.out_valid", i), 32'(out_valid16[0]), 32'd1);
            check($sformatf("bp%0d.sum", i), 32'(sum16[0]), 32'(bp.s));
            check($sformatf("bp%0d.cout_ovf", i), 32'({cout16[0], ovf16[0]}), 32'd0);
            check($sformatf("bp%0d.in_ready", i), 32'(in_ready16[0]), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp.out_valid_drop", 32'(out_valid16[0]), 32'd0);
        check("bp.in_ready_back", 32'(in_ready16[0]), 32'd1);

        // Reset on the second RUN cycle aborts; a following op still works.
        for (int k = 0; k < 3; k++) begin
            a16 = 16'hAAAA; b16 = 16'h5555; cin = 1'b1; sub = 1'b0;
            in_valid16[k] = 1'b1;
            @(negedge clk);
            in_valid16[k] = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check($sformatf("abort%0d.in_ready", k), 32'(in_ready16[k]), 32'd1);
            check($sformatf("abort%0d.out_valid", k), 32'(out_valid16[k]), 32'd0);
            check($sformatf("abort%0d.sum", k), 32'(sum16[k]), 32'd0);
            run16(k, vecs[4], $sformatf("post_abort%0d", k));
        end

        // Exhaustive WIDTH=4 add: {cout,sum} = a+b+cin, ovf from signed range.
        sub = 1'b0;
        for (int i = 0; i < 512; i++) begin
            logic [3:0] va, vb;
            logic       vc;
            int         n, sa, sb, ss;
            va = 4'(i); vb = 4'(i >> 4); vc = 1'(i >> 8);
            a4 = va; b4 = vb; cin = vc; in_valid4 = 1'b1;
            @(negedge clk);
            in_valid4 = 1'b0;
            n = 0;
            while (!out_valid4 && n < 16) begin
                @(negedge clk);
                n++;
            end
            sa = va[3] ? int'(va) - 16 : int'(va);
            sb = vb[3] ? int'(vb) - 16 : int'(vb);
            ss = sa + sb + int'(vc);
            check($sformatf("w4.%0h+%0h+%0d.latency", va, vb, vc), 32'(n), 32'd1);
            check($sformatf("w4.%0h+%0h+%0d.sum", va, vb, vc), 32'({cout4, sum4}),
                  32'(int'(va) + int'(vb) + int'(vc)));
            check($sformatf("w4.%0h+%0h+%0d.ovf", va, vb, vc), 32'(ovf4),
                  32'((ss > 7 || ss < -8) ? 1 : 0));
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
